// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit prefetch queue.
package ifu_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned PC_STEP     = DEF_INSTR_W / 8;

    // Queue payload; layout follows the package default widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Saturating increment for the optional performance counters.
    function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/ifu_prefetch_queue_if.sv
// Memory request/response and decode-side handshake bundle for the fetch unit.
interface ifu_prefetch_queue_if
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               dec_valid;
    logic               dec_ready;
    logic [ADDR_W-1:0]  dec_pc;
    logic [INSTR_W-1:0] dec_instr;

    modport master (
        output mem_req_valid, mem_req_addr, dec_valid, dec_pc, dec_instr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, dec_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, dec_valid, dec_pc, dec_instr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, dec_ready
    );
endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with clear; push while full is accepted when a pop happens the same cycle.
module ifu_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop & (count != '0);
    assign do_push  = push & ((count != CNT_W'(DEPTH)) | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ifu_prefetch_queue.sv
// Sequential instruction prefetcher with credit-limited requests, redirect flush and
// in-flight response dropping. Optional counters enabled by IFU_PERF_CNT_EN.
module ifu_prefetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned      ADDR_W   = DEF_ADDR_W,
    parameter int unsigned      INSTR_W  = DEF_INSTR_W,
    parameter int unsigned      DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_flag,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   if_id_flush,
    output logic                   misaligned,
    output logic [$clog2(DEPTH):0] queue_count,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_dropped,
    output logic [31:0]            perf_stall,
`endif
    ifu_prefetch_queue_if.master   bus
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned DROP_W = CNT_W + 4;
    localparam int unsigned STEP   = INSTR_W / 8;
    localparam int unsigned OFS_W  = $clog2(STEP);

    logic [ADDR_W-1:0] pc;
    logic [DROP_W-1:0] drop;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  outstanding;
    logic [ADDR_W-1:0] tag_pc;
    fetch_entry_t      q_in;
    fetch_entry_t      q_out;
    logic              has_credit;
    logic              req_fire;
    logic              rsp_take;
    logic              deq;

    // Queue plus in-flight requests never exceed DEPTH, so a response always has a slot.
    assign has_credit        = (SUM_W'(q_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
    assign bus.mem_req_valid = run_flag & ~redirect_valid & has_credit;
    assign bus.mem_req_addr  = pc;
    assign req_fire          = bus.mem_req_valid & bus.mem_req_ready;
    assign rsp_take          = bus.mem_rsp_valid & ~redirect_valid & (drop == '0);
    assign deq               = bus.dec_valid & bus.dec_ready & ~redirect_valid;
    assign q_in              = '{pc: tag_pc, instr: bus.mem_rsp_data};

    assign bus.dec_valid = (q_count != '0);
    assign bus.dec_pc    = bus.dec_valid ? q_out.pc : '0;
    assign bus.dec_instr = bus.dec_valid ? q_out.instr : '0;
    assign queue_count   = q_count;

    // Tag FIFO occupancy doubles as the outstanding-request count.
    ifu_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_valid),
        .push     (req_fire),
        .push_data(pc),
        .pop      (rsp_take),
        .pop_data (tag_pc),
        .count    (outstanding)
    );

    ifu_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_valid),
        .push     (rsp_take),
        .push_data(q_in),
        .pop      (deq),
        .pop_data (q_out),
        .count    (q_count)
    );

    // On redirect every still-expected response (dropped or tagged) becomes a drop,
    // less the one arriving this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            drop        <= '0;
            if_id_flush <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            if_id_flush <= redirect_valid;
            misaligned  <= redirect_valid & (|redirect_pc[OFS_W-1:0]);
            if (redirect_valid) begin
                pc   <= {redirect_pc[ADDR_W-1:OFS_W], OFS_W'(0)};
                drop <= drop + DROP_W'(outstanding) - DROP_W'(bus.mem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + ADDR_W'(STEP);
                if (bus.mem_rsp_valid && (drop != '0)) drop <= drop - DROP_W'(1);
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic rsp_discard;
    assign rsp_discard = bus.mem_rsp_valid & ~rsp_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= sat_inc(perf_fetched, rsp_take);
            perf_dropped <= sat_inc(perf_dropped, rsp_discard);
            perf_stall   <= sat_inc(perf_stall, bus.dec_valid & ~bus.dec_ready);
        end
    end
`endif
endmodule
